// File: rtl/cache_pkg.sv
// Shared state encoding and default sizing for the 2-way
// set-associative write-back cache controller.
package cache_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int INDEX_W_DEF = 4;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITEBACK,
        ST_REFILL,
        ST_RESPOND
    } state_e;

endpackage

// File: rtl/cache_way_array.sv
// One cache way: per-set valid, dirty, tag and data storage with an
// asynchronous read port and a single synchronous write port.
module cache_way_array
    import cache_pkg::*;
#(
    parameter int TAG_W   = ADDR_W_DEF - INDEX_W_DEF - 2,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int INDEX_W = INDEX_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               we,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic               wr_dirty,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data
);

    localparam int SETS = 2 ** INDEX_W;

    logic [SETS-1:0]   valid_q, valid_d;
    logic [SETS-1:0]   dirty_q, dirty_d;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [TAG_W-1:0]  tag_d  [SETS];
    logic [DATA_W-1:0] data_q [SETS];
    logic [DATA_W-1:0] data_d [SETS];

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (we) begin
            valid_d[wr_idx] = 1'b1;
            dirty_d[wr_idx] = wr_dirty;
            tag_d[wr_idx]   = wr_tag;
            data_d[wr_idx]  = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag/data need no reset: valid gates every use of them.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/assoc_cache_control.sv
// 2-way set-associative, write-back, write-allocate cache controller
// with per-set LRU and saturating hit/miss statistics.
module assoc_cache_control
    import cache_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int INDEX_W = INDEX_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rEn,
    input  logic              wEn,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              cpu_ready,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int TAG_W = ADDR_W - INDEX_W - 2;
    localparam int SETS  = 2 ** INDEX_W;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_op_q, wr_op_d;
    logic              way_q, way_d;
    logic [SETS-1:0]   lru_q, lru_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [ADDR_W-1:0]  line_addr;
    logic [INDEX_W-1:0] req_idx, lat_idx;
    logic [TAG_W-1:0]   req_tag, lat_tag;

    logic [1:0]         rd_valid, rd_dirty, way_hit, way_we;
    logic [TAG_W-1:0]   rd_tag  [2];
    logic [DATA_W-1:0]  rd_data [2];
    logic [INDEX_W-1:0] wr_idx;
    logic               wr_dirty;
    logic [TAG_W-1:0]   wr_tag;
    logic [DATA_W-1:0]  wr_data;
    logic               hit, hit_way, victim;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign line_addr = address & ~ADDR_W'(3);
    assign req_idx   = line_addr[INDEX_W+1:2];
    assign req_tag   = line_addr[ADDR_W-1:INDEX_W+2];
    assign lat_idx   = addr_q[INDEX_W+1:2];
    assign lat_tag   = addr_q[ADDR_W-1:INDEX_W+2];

    for (genvar w = 0; w < 2; w++) begin : g_way
        cache_way_array #(
            .TAG_W  (TAG_W),
            .DATA_W (DATA_W),
            .INDEX_W(INDEX_W)
        ) u_way (
            .clk     (clk),
            .rst     (rst),
            .rd_idx  (req_idx),
            .rd_valid(rd_valid[w]),
            .rd_dirty(rd_dirty[w]),
            .rd_tag  (rd_tag[w]),
            .rd_data (rd_data[w]),
            .we      (way_we[w]),
            .wr_idx  (wr_idx),
            .wr_dirty(wr_dirty),
            .wr_tag  (wr_tag),
            .wr_data (wr_data)
        );
        assign way_hit[w] = rd_valid[w] && (rd_tag[w] == req_tag);
    end

    assign hit     = |way_hit;
    assign hit_way = way_hit[1];
    assign victim  = !rd_valid[0] ? 1'b0 :
                     !rd_valid[1] ? 1'b1 : lru_q[req_idx];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_op_d     = wr_op_q;
        way_d       = way_q;
        lru_d       = lru_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        rdata_d     = rdata_q;
        cpu_ready_d = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        way_we      = 2'b00;
        wr_idx      = req_idx;
        wr_dirty    = 1'b0;
        wr_tag      = req_tag;
        wr_data     = wdata;

        unique case (state_q)
            ST_IDLE: begin
                if (!cpu_ready_q && (rEn || wEn)) begin
                    if (hit) begin
                        cpu_ready_d    = 1'b1;
                        hit_cnt_d      = sat_inc(hit_cnt_q);
                        lru_d[req_idx] = ~hit_way;
                        if (wEn) begin
                            way_we[hit_way] = 1'b1;
                            wr_dirty        = 1'b1;
                        end else begin
                            rdata_d = rd_data[hit_way];
                        end
                    end else begin
                        miss_cnt_d = sat_inc(miss_cnt_q);
                        addr_d     = line_addr;
                        wdata_d    = wdata;
                        wr_op_d    = wEn;
                        way_d      = victim;
                        mem_req_d  = 1'b1;
                        if (rd_valid[victim] && rd_dirty[victim]) begin
                            state_d     = ST_WRITEBACK;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = {rd_tag[victim], req_idx, 2'b00};
                            mem_wdata_d = rd_data[victim];
                        end else begin
                            state_d    = ST_REFILL;
                            mem_we_d   = 1'b0;
                            mem_addr_d = line_addr;
                        end
                    end
                end
            end
            ST_WRITEBACK: begin
                // Drop the strobe for a cycle before the refill request.
                if (mem_req_q && mem_ready) begin
                    state_d    = ST_REFILL;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    mem_addr_d = addr_q;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            ST_REFILL: begin
                if (mem_req_q && mem_ready) begin
                    state_d        = ST_RESPOND;
                    mem_req_d      = 1'b0;
                    cpu_ready_d    = 1'b1;
                    way_we[way_q]  = 1'b1;
                    wr_idx         = lat_idx;
                    wr_tag         = lat_tag;
                    wr_dirty       = wr_op_q;
                    wr_data        = wr_op_q ? wdata_q : mem_rdata;
                    lru_d[lat_idx] = ~way_q;
                    if (!wr_op_q) begin
                        rdata_d = mem_rdata;
                    end
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (rst) begin
            way_we = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_op_q     <= 1'b0;
            way_q       <= 1'b0;
            lru_q       <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            rdata_q     <= '0;
            cpu_ready_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_op_q     <= wr_op_d;
            way_q       <= way_d;
            lru_q       <= lru_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            rdata_q     <= rdata_d;
            cpu_ready_q <= cpu_ready_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign rdata     = rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign busy      = (state_q != ST_IDLE) || cpu_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_assoc_cache_control.sv
// Bench for assoc_cache_control: directed table, reset-abort case,
// and random traffic against a set/LRU-list reference model.
module tb_assoc_cache_control;

    localparam logic [31:0] KEY = 32'h9B9F9B97;

    logic        clk = 1'b0;
    logic        rst;
    logic        rEn, wEn;
    logic [31:0] address, wdata, rdata;
    logic        cpu_ready, busy;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;
    logic [15:0] hit_cnt, miss_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assoc_cache_control dut (
        .clk      (clk),
        .rst      (rst),
        .rEn      (rEn),
        .wEn      (wEn),
        .address  (address),
        .wdata    (wdata),
        .rdata    (rdata),
        .cpu_ready(cpu_ready),
        .busy     (busy),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    typedef struct {
        int          n_ready;
        int          n_wb;
        int          n_fill;
        logic [31:0] wb_addr;
        logic [31:0] wb_data;
        logic [31:0] fill_addr;
        logic [31:0] rdata;
        int          dh;
        int          dm;
        bit          timeout;
        bit          stuck;
    } obs_t;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        bit          exp_hit;
        logic [31:0] exp_rdata;
        bit          exp_wb;
        logic [31:0] exp_wba;
        logic [31:0] exp_wbd;
    } vec_t;

    // Backing memory (what the DUT wrote back) and architectural values.
    logic [31:0] mem_store [logic [31:0]];
    logic [31:0] arch      [logic [31:0]];
    logic [31:0] set_a [16][2];
    bit          set_d [16][2];
    int          set_n [16];

    function automatic logic [31:0] mem_get(input logic [31:0] a);
        return mem_store.exists(a) ? mem_store[a] : (a ^ KEY);
    endfunction

    function automatic logic [31:0] arch_get(input logic [31:0] a);
        return arch.exists(a) ? arch[a] : (a ^ KEY);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int s = 0; s < 16; s++) set_n[s] = 0;
        arch.delete();
        mem_store.delete();
    endtask

    // Each set is a most-recent-first list of at most two lines.
    task automatic mdl_access(input logic [31:0] araw, input bit wr, input logic [31:0] d,
                              output bit hit, output bit wb,
                              output logic [31:0] wba, output logic [31:0] wbd);
        logic [31:0] a, ta;
        bit td;
        int s, k;
        a = araw & ~32'd3;
        s = int'(a[5:2]);
        k = -1;
        hit = 0; wb = 0; wba = '0; wbd = '0;
        for (int i = 0; i < set_n[s]; i++) if (set_a[s][i] == a) k = i;
        if (k >= 0) begin
            hit = 1;
            if (k == 1) begin
                ta = set_a[s][0]; td = set_d[s][0];
                set_a[s][0] = set_a[s][1]; set_d[s][0] = set_d[s][1];
                set_a[s][1] = ta; set_d[s][1] = td;
            end
            if (wr) set_d[s][0] = 1;
        end else begin
            if (set_n[s] == 2 && set_d[s][1]) begin
                wb = 1; wba = set_a[s][1]; wbd = arch_get(wba);
            end
            set_a[s][1] = set_a[s][0]; set_d[s][1] = set_d[s][0];
            set_a[s][0] = a; set_d[s][0] = wr;
            if (set_n[s] < 2) set_n[s]++;
        end
        if (wr) arch[a] = d;
    endtask

    task automatic do_access(input bit rd, input bit wr, input logic [31:0] a,
                             input logic [31:0] d, input int lat, input bit hold,
                             output obs_t o);
        logic [15:0] h0, m0;
        int cnt, cyc, guard;
        bit done, acked;
        o = '{default: 0};
        guard = 0;
        while (busy && guard < 20) begin @(negedge clk); guard++; end
        h0 = hit_cnt; m0 = miss_cnt;
        rEn = rd; wEn = wr; address = a; wdata = d;
        @(negedge clk);
        rEn = hold; wEn = hold;
        cnt = 0; cyc = 0; done = 0; acked = 0;
        while (!done && cyc < 100) begin
            mem_ready = 0;
            mem_rdata = 32'hDEADBEEF;
            if (acked && mem_req) o.stuck = 1;
            acked = 0;
            if (cpu_ready) begin
                o.n_ready++;
                rEn = 0; wEn = 0;
                done = 1;
            end else if (mem_req) begin
                cnt++;
                if (cnt >= lat) begin
                    mem_ready = 1; acked = 1; cnt = 0;
                    if (mem_we) begin
                        o.n_wb++; o.wb_addr = mem_addr; o.wb_data = mem_wdata;
                        mem_store[mem_addr] = mem_wdata;
                    end else begin
                        o.n_fill++; o.fill_addr = mem_addr;
                        mem_rdata = mem_get(mem_addr);
                    end
                end
            end
            if (!done) begin @(negedge clk); cyc++; end
        end
        rEn = 0; wEn = 0; mem_ready = 0;
        o.timeout = !done;
        o.rdata = rdata;
        o.dh = int'(hit_cnt - h0);
        o.dm = int'(miss_cnt - m0);
        repeat (3) begin
            @(negedge clk);
            if (cpu_ready) o.n_ready++;
        end
    endtask

    task automatic check_obs(input string nm, input obs_t o, input logic [31:0] a,
                             input bit exp_hit, input logic [31:0] exp_rdata,
                             input bit exp_wb, input logic [31:0] wba, input logic [31:0] wbd);
        chk({nm, "/timeout"}, 32'(o.timeout), 32'd0);
        chk({nm, "/hit_delta"}, 32'(o.dh), 32'(exp_hit));
        chk({nm, "/miss_delta"}, 32'(o.dm), 32'(!exp_hit));
        chk({nm, "/ready_pulses"}, 32'(o.n_ready), 32'd1);
        chk({nm, "/rdata"}, o.rdata, exp_rdata);
        chk({nm, "/wb_count"}, 32'(o.n_wb), 32'(exp_wb));
        if (exp_wb) begin
            chk({nm, "/wb_addr"}, o.wb_addr, wba);
            chk({nm, "/wb_data"}, o.wb_data, wbd);
        end
        chk({nm, "/fill_count"}, 32'(o.n_fill), 32'(!exp_hit));
        if (!exp_hit) chk({nm, "/fill_addr"}, o.fill_addr, a & ~32'd3);
        chk({nm, "/req_drop"}, 32'(o.stuck), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1;
        rEn = 0; wEn = 0; address = '0; wdata = '0;
        mem_ready = 0; mem_rdata = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        rst = 0;
    endtask

    vec_t tbl [10];
    obs_t o;

    initial begin
        tbl[0] = '{1, 0, 32'h12345678, 32'h0,        3, 0, 32'h89ABCDEF, 0, 32'h0, 32'h0};
        tbl[1] = '{1, 0, 32'h12345678, 32'h0,        1, 1, 32'h89ABCDEF, 0, 32'h0, 32'h0};
        tbl[2] = '{0, 1, 32'h12345678, 32'h11111111, 1, 1, 32'h89ABCDEF, 0, 32'h0, 32'h0};
        tbl[3] = '{1, 0, 32'h22345678, 32'h0,        2, 0, 32'hB9ABCDEF, 0, 32'h0, 32'h0};
        tbl[4] = '{1, 0, 32'h32345678, 32'h0,        2, 0, 32'hA9ABCDEF, 1, 32'h12345678, 32'h11111111};
        tbl[5] = '{1, 0, 32'h12345679, 32'h0,        1, 0, 32'h11111111, 0, 32'h0, 32'h0};
        tbl[6] = '{1, 1, 32'h12345678, 32'h55AA55AA, 1, 1, 32'h11111111, 0, 32'h0, 32'h0};
        tbl[7] = '{1, 0, 32'h1234567B, 32'h0,        1, 1, 32'h55AA55AA, 0, 32'h0, 32'h0};
        tbl[8] = '{1, 0, 32'h42345678, 32'h0,        4, 0, 32'hD9ABCDEF, 0, 32'h0, 32'h0};
        tbl[9] = '{1, 0, 32'h52345678, 32'h0,        1, 0, 32'hC9ABCDEF, 1, 32'h12345678, 32'h55AA55AA};

        mdl_reset();
        do_reset();
        chk("reset/rdata", rdata, 32'h0);
        chk("reset/ctrl", {28'h0, cpu_ready, busy, mem_req, mem_we}, 32'h0);
        chk("reset/mem_addr", mem_addr, 32'h0);
        chk("reset/mem_wdata", mem_wdata, 32'h0);
        chk("reset/counters", {hit_cnt, miss_cnt}, 32'h0);

        for (int i = 0; i < 10; i++) begin
            do_access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].lat, 1'b0, o);
            check_obs($sformatf("vec%0d", i), o, tbl[i].addr, tbl[i].exp_hit,
                      tbl[i].exp_rdata, tbl[i].exp_wb, tbl[i].exp_wba, tbl[i].exp_wbd);
        end
        chk("table/hit_cnt", 32'(hit_cnt), 32'd4);
        chk("table/miss_cnt", 32'(miss_cnt), 32'd6);

        // Requests held high throughout a miss must not be re-accepted.
        do_access(1'b1, 1'b0, 32'h9ABCDEF0, 32'h0, 2, 1'b1, o);
        check_obs("held_req", o, 32'h9ABCDEF0, 0, 32'h01234567, 0, 32'h0, 32'h0);

        // Reset in the middle of a refill.
        @(negedge clk);
        rEn = 1; address = 32'h0ABC0010;
        @(negedge clk);
        rEn = 0;
        repeat (2) @(negedge clk);
        chk("abort/in_refill", 32'(mem_req), 32'd1);
        rst = 1;
        @(negedge clk);
        chk("abort/req_drop", 32'(mem_req), 32'd0);
        chk("abort/busy", 32'(busy), 32'd0);
        rst = 0;
        mdl_reset();
        do_access(1'b1, 1'b0, 32'h0ABC0010, 32'h0, 1, 1'b0, o);
        check_obs("abort/reread", o, 32'h0ABC0010, 0, 32'h91239B87, 0, 32'h0, 32'h0);
        chk("abort/miss_cnt", 32'(miss_cnt), 32'd1);

        // Random traffic over four sets and six tags.
        do_reset();
        mdl_reset();
        begin
            logic [31:0] a, d, wba, wbd, last_rd, exp_rd;
            bit rd, wr, hit, wb;
            int op;
            last_rd = '0;
            for (int n = 0; n < 300; n++) begin
                a = (32'($urandom_range(0, 5)) << 6) | (32'($urandom_range(0, 3)) << 2)
                    | 32'($urandom_range(0, 3));
                op = int'($urandom_range(0, 3));
                rd = (op != 2);
                wr = (op >= 2);
                d = $urandom;
                mdl_access(a, wr, d, hit, wb, wba, wbd);
                if (!wr) last_rd = arch_get(a & ~32'd3);
                exp_rd = last_rd;
                do_access(rd, wr, a, d, int'($urandom_range(1, 4)),
                          1'($urandom_range(0, 1)), o);
                check_obs($sformatf("rnd%0d", n), o, a, hit, exp_rd, wb, wba, wbd);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
